// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite SRAM slave: registered address phase, configurable wait states on every
// OKAY data phase, and a two-cycle ERROR response for bad transfers.
module ahb3lite_sram_ws #(
   parameter int HADDR_SIZE  = 32,
   parameter int HDATA_SIZE  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [HADDR_SIZE-1:0] HADDR,
   input  logic [HDATA_SIZE-1:0] HWDATA,
   output logic [HDATA_SIZE-1:0] HRDATA,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [1:0]            HTRANS,
   output logic                  HREADYOUT,
   input  logic                  HREADY,
   output logic                  HRESP
);
   localparam int NB    = HDATA_SIZE / 8;
   localparam int BW    = $clog2(NB);
   localparam int AW    = $clog2(MEM_DEPTH);
   localparam int BYTES = MEM_DEPTH * NB;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACC, S_ERR1, S_ERR2} state_t;

   state_t           state, state_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic [AW+BW-1:0] addr_q;
   logic [2:0]       size_q;
   logic             write_q, err_q;
   logic             open, accept, err_in, we;
   logic [6:0]       amask;
   logic [AW-1:0]    widx;
   logic [BW-1:0]    off;
   logic [NB-1:0]    lane_en;
   logic [NB-1:0][7:0] mem [MEM_DEPTH];

   // HBURST/HPROT carry no behaviour; HTRANS[0] only separates IDLE/BUSY and NONSEQ/SEQ.
   logic unused_ok;
   assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

   // Slave can only take a new address phase while its own HREADYOUT is high.
   assign open   = (state == S_IDLE) || (state == S_ACC) || (state == S_ERR2);
   assign accept = open & HSEL & HREADY & HTRANS[1];

   assign amask  = (7'd1 << HSIZE) - 7'd1;
   assign err_in = (HADDR >= HADDR_SIZE'(BYTES)) ||
                   (HSIZE > 3'(BW)) ||
                   (|(HADDR[6:0] & amask));

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state   <= S_IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            addr_q  <= HADDR[AW+BW-1:0];
            size_q  <= HSIZE;
            write_q <= HWRITE;
            err_q   <= err_in;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      case (state)
         S_WAIT: begin
            HREADYOUT = 1'b0;
            if (cnt == 4'd0) state_nxt = S_ACC;
            else             cnt_nxt   = cnt - 4'd1;
         end
         S_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
            state_nxt = S_ERR2;
         end
         S_ERR2:  HRESP = 1'b1;
         default: ;
      endcase
      if (open) begin
         if (!accept)              state_nxt = S_IDLE;
         else if (err_in)          state_nxt = S_ERR1;
         else if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_STATES - 1);
         end else                  state_nxt = S_ACC;
      end
   end

   assign widx = addr_q[BW +: AW];
   assign off  = addr_q[BW-1:0];
   assign we   = (state == S_ACC) && write_q && !err_q;

   // Little-endian byte lanes covered by the registered size/offset.
   always_comb begin
      lane_en = '0;
      for (int b = 0; b < NB; b++)
         lane_en[b] = (b >= int'(off)) && (b < int'(off) + (1 << size_q));
   end

   always_ff @(posedge HCLK) begin
      if (we)
         for (int b = 0; b < NB; b++)
            if (lane_en[b]) mem[widx][b] <= HWDATA[8*b +: 8];
   end

   assign HRDATA = ((state == S_ACC) && !write_q && !err_q) ? mem[widx] : '0;

endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// Directed bench for ahb3lite_sram_ws: three instances (0, 3 and 2 wait states) share the bus.
module tb_ahb3lite_sram_ws;
   logic        HCLK = 1'b0, HRESETn = 1'b0;
   logic        HSEL = 1'b0, HWRITE = 1'b0, force_lo = 1'b0;
   logic [31:0] HADDR = '0, HWDATA = '0;
   logic [2:0]  HSIZE = 3'd2, HBURST = '0;
   logic [3:0]  HPROT = '0;
   logic [1:0]  HTRANS = '0;
   logic [2:0]  ho, hrsp, hrdy;
   logic [2:0][31:0] rdv;

   int          sel = 0, n_chk = 0, n_err = 0;
   logic [31:0] r;
   int          w;
   logic        p0, p;

   always #5 HCLK = ~HCLK;

   // Each slave sees its own HREADYOUT as HREADY unless the bench pulls it low.
   assign hrdy = force_lo ? 3'b000 : ho;

   ahb3lite_sram_ws #(.WAIT_STATES(0)) u_ws0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
      .HRDATA(rdv[0]), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HTRANS(HTRANS), .HREADYOUT(ho[0]), .HREADY(hrdy[0]), .HRESP(hrsp[0]));
   ahb3lite_sram_ws #(.WAIT_STATES(3)) u_ws3 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
      .HRDATA(rdv[1]), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HTRANS(HTRANS), .HREADYOUT(ho[1]), .HREADY(hrdy[1]), .HRESP(hrsp[1]));
   ahb3lite_sram_ws #(.WAIT_STATES(2)) u_ws2 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
      .HRDATA(rdv[2]), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HTRANS(HTRANS), .HREADYOUT(ho[2]), .HREADY(hrdy[2]), .HRESP(hrsp[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   // Single non-pipelined transfer on the selected instance; returns data, wait count, responses.
   task automatic xfer(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rdat, output int waits,
                       output logic resp0, output logic resp);
      int guard = 0;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HSIZE = sz; HADDR = a;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = wd;
      waits = 0;
      @(negedge HCLK);
      resp0 = hrsp[sel];
      while (!ho[sel] && guard < 40) begin
         waits++; guard++;
         @(negedge HCLK);
      end
      if (guard >= 40) chk("timeout", 32'(ho[sel]), 32'd1);
      rdat = rdv[sel];
      resp = hrsp[sel];
      @(posedge HCLK); #1;
   endtask

   task automatic nontx(input logic s, input logic [1:0] t, input logic f, input string tag);
      HSEL = s; HTRANS = t; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h10; force_lo = f;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; force_lo = 1'b0; HWDATA = 32'h12345678;
      @(negedge HCLK);
      chk({tag, "_ready"}, 32'(ho[0]), 32'd1);
      chk({tag, "_resp"}, 32'(hrsp[0]), 32'd0);
      @(posedge HCLK); #1;
   endtask

   task automatic chk_err(input string tag);
      chk({tag, "_resp_err1"}, 32'(p0), 32'd1);
      chk({tag, "_waits"}, 32'(w), 32'd1);
      chk({tag, "_resp_err2"}, 32'(p), 32'd1);
   endtask

   // Let every instance drain before focusing on another one.
   task automatic sw(input int s);
      HSEL = 1'b0; HTRANS = 2'b00;
      repeat (6) @(posedge HCLK);
      #1 sel = s;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_ready%0d", i), 32'(ho[i]), 32'd1);
         chk($sformatf("rst_resp%0d", i), 32'(hrsp[i]), 32'd0);
         chk($sformatf("rst_rdata%0d", i), rdv[i], 32'd0);
      end
      @(posedge HCLK); #1 HRESETn = 1'b1;
      @(posedge HCLK); #1;

      // Pipelined write then read of the same word, zero wait states.
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h10;
      @(posedge HCLK); #1;
      HWDATA = 32'hDEADBEEF; HWRITE = 1'b0;
      @(negedge HCLK);
      chk("t1_wr_ready", 32'(ho[0]), 32'd1);
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00;
      @(negedge HCLK);
      chk("t1_rd_ready", 32'(ho[0]), 32'd1);
      chk("t1_rdata", rdv[0], 32'hDEADBEEF);
      @(posedge HCLK); #1;

      // Sub-word writes on lanes 3, 3:2 and 0.
      xfer(1'b1, 3'd2, 32'h10, 32'h11223344, r, w, p0, p);
      xfer(1'b1, 3'd0, 32'h13, 32'hAA000000, r, w, p0, p);
      xfer(1'b0, 3'd2, 32'h10, 32'h0, r, w, p0, p);
      chk("t3_byte", r, 32'hAA223344);
      xfer(1'b1, 3'd1, 32'h12, 32'h55660000, r, w, p0, p);
      xfer(1'b0, 3'd2, 32'h10, 32'h0, r, w, p0, p);
      chk("t3_half", r, 32'h55663344);
      xfer(1'b1, 3'd0, 32'h10, 32'h000000EE, r, w, p0, p);
      xfer(1'b0, 3'd2, 32'h10, 32'h0, r, w, p0, p);
      chk("t3_byte0", r, 32'h556633EE);

      // Error responses leave memory untouched.
      xfer(1'b1, 3'd2, 32'h00, 32'h01020304, r, w, p0, p);
      xfer(1'b0, 3'd2, 32'h400, 32'h0, r, w, p0, p);
      chk_err("t4_range");
      chk("t4_range_rdata", r, 32'd0);
      xfer(1'b1, 3'd2, 32'h02, 32'hFFFFFFFF, r, w, p0, p);
      chk_err("t4_align");
      xfer(1'b0, 3'd2, 32'h00, 32'h0, r, w, p0, p);
      chk("t4_align_mem", r, 32'h01020304);
      xfer(1'b1, 3'd3, 32'h10, 32'hFFFFFFFF, r, w, p0, p);
      chk_err("t4_size");
      xfer(1'b0, 3'd2, 32'h10, 32'h0, r, w, p0, p);
      chk("t4_size_mem", r, 32'h556633EE);
      xfer(1'b1, 3'd2, 32'h3FC, 32'h0BADCAFE, r, w, p0, p);
      chk("t4_last_resp", 32'(p), 32'd0);
      xfer(1'b0, 3'd2, 32'h3FC, 32'h0, r, w, p0, p);
      chk("t4_last_rdata", r, 32'h0BADCAFE);

      // Non-transfers: IDLE, BUSY, deselected, and HREADY low.
      nontx(1'b1, 2'b00, 1'b0, "t5_idle");
      nontx(1'b1, 2'b01, 1'b0, "t5_busy");
      nontx(1'b0, 2'b10, 1'b0, "t5_nosel");
      nontx(1'b1, 2'b10, 1'b1, "t5_hready");
      xfer(1'b0, 3'd2, 32'h10, 32'h0, r, w, p0, p);
      chk("t5_mem", r, 32'h556633EE);

      // Three wait states.
      sw(1);
      xfer(1'b1, 3'd2, 32'h04, 32'hCAFEF00D, r, w, p0, p);
      chk("t2_wr_waits", 32'(w), 32'd3);
      xfer(1'b0, 3'd2, 32'h04, 32'h0, r, w, p0, p);
      chk("t2_rd_waits", 32'(w), 32'd3);
      chk("t2_resp_wait", 32'(p0), 32'd0);
      chk("t2_resp", 32'(p), 32'd0);
      chk("t2_rdata", r, 32'hCAFEF00D);

      // INCR4 burst with two wait states, reset during beat 2.
      sw(2);
      for (int i = 0; i < 4; i++) xfer(1'b1, 3'd2, 32'h20 + 32'(4*i), 32'h0, r, w, p0, p);
      chk("t6_pre_waits", 32'(w), 32'd2);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HBURST = 3'b011; HADDR = 32'h20;
      @(posedge HCLK); #1;
      HTRANS = 2'b11; HADDR = 32'h24; HWDATA = 32'hB0000001;
      @(negedge HCLK); chk("t6_b1_w1", 32'(ho[2]), 32'd0);
      @(negedge HCLK); chk("t6_b1_w2", 32'(ho[2]), 32'd0);
      @(negedge HCLK); chk("t6_b1_acc", 32'(ho[2]), 32'd1);
      @(posedge HCLK); #1;
      HADDR = 32'h28; HWDATA = 32'hB0000002;
      @(negedge HCLK); chk("t6_b2_wait", 32'(ho[2]), 32'd0);
      #1 HRESETn = 1'b0;
      #1;
      chk("t6_rst_ready", 32'(ho[2]), 32'd1);
      chk("t6_rst_resp", 32'(hrsp[2]), 32'd0);
      chk("t6_rst_rdata", rdv[2], 32'd0);
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HBURST = 3'b000;
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;
      @(posedge HCLK); #1;
      xfer(1'b0, 3'd2, 32'h20, 32'h0, r, w, p0, p);
      chk("t6_beat1", r, 32'hB0000001);
      for (int i = 1; i < 4; i++) begin
         xfer(1'b0, 3'd2, 32'h20 + 32'(4*i), 32'h0, r, w, p0, p);
         chk($sformatf("t6_beat%0d", i + 1), r, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
